// File: rtl/pipelined_barrel_shifter.sv
// Pipelined log2 barrel shifter: SLL/SRL/SRA plus RV64 word-mode variants,
// with valid/ready handshakes on both sides and LVL_PER_STG mux levels per stage.
module pipelined_barrel_shifter #(
    parameter int unsigned XLEN        = 64,
    parameter int unsigned SHAMT_W     = 6,
    parameter int unsigned LVL_PER_STG = 2,
    parameter bit          HAS_WORD    = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [XLEN-1:0]    in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic [1:0]         in_op,
    input  logic               word_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XLEN-1:0]    out_data
);

    localparam int unsigned NSTG    = (SHAMT_W + LVL_PER_STG - 1) / LVL_PER_STG;
    localparam bit          WORD_EN = HAS_WORD && (XLEN == 64);

    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b11;

    typedef struct packed {
        logic [XLEN-1:0]    data;
        logic [SHAMT_W-1:0] shamt;
        logic [1:0]         op;
        logic               wm;
    } stg_t;

    logic [NSTG-1:0] vld_q;
    logic [NSTG-1:0] vld_d;
    logic [NSTG-1:0] adv;
    stg_t            stg_q [NSTG];
    stg_t            stg_d [NSTG];
    stg_t            pre;

    // One barrel level: shift by 2^k in the direction/fill selected by op.
    function automatic logic [XLEN-1:0] shift_lvl(input logic [XLEN-1:0] d,
                                                  input logic [1:0]      op,
                                                  input int              k);
        case (op)
            OP_SRL:  return d >> (1 << k);
            OP_SRA:  return XLEN'($signed(d) >>> (1 << k));
            default: return d << (1 << k);
        endcase
    endfunction

    // Walk back from the output: a stage advances when everything downstream can move.
    always_comb begin
        logic free;
        adv  = '0;
        free = out_ready;
        for (int i = int'(NSTG) - 1; i >= 0; i--) begin
            adv[i] = vld_q[i] & free;
            free   = ~vld_q[i] | adv[i];
        end
        in_ready = free;
    end

    // Word mode pre-extends the low word so full-width right shifts fill correctly.
    always_comb begin
        pre       = '0;
        pre.op    = in_op;
        pre.wm    = WORD_EN && word_mode;
        pre.shamt = in_shamt;
        pre.data  = in_data;
        if (pre.wm) begin
            pre.shamt = in_shamt & SHAMT_W'(31);
            pre.data  = (in_op == OP_SRA) ? XLEN'($signed(in_data[31:0]))
                                          : XLEN'(in_data[31:0]);
        end
    end

    // Per-stage mux levels, load/hold of stage payloads and valid tracking.
    always_comb begin
        stg_t cur;
        logic take;
        stg_d = stg_q;
        vld_d = vld_q;
        take  = in_valid & in_ready;
        cur   = pre;
        for (int s = 0; s < int'(NSTG); s++) begin
            for (int k = 0; k < int'(SHAMT_W); k++) begin
                if ((k >= s * int'(LVL_PER_STG)) && (k < (s + 1) * int'(LVL_PER_STG))
                    && cur.shamt[k]) begin
                    cur.data = shift_lvl(cur.data, cur.op, k);
                end
            end
            if ((s == int'(NSTG) - 1) && cur.wm) begin
                cur.data = XLEN'($signed(cur.data[31:0]));
            end
            stg_d[s] = take ? cur : stg_q[s];
            vld_d[s] = take | (vld_q[s] & ~adv[s]);
            take     = adv[s];
            cur      = stg_q[s];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            for (int s = 0; s < int'(NSTG); s++) begin
                stg_q[s] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            for (int s = 0; s < int'(NSTG); s++) begin
                stg_q[s] <= stg_d[s];
            end
        end
    end

    assign out_valid = vld_q[NSTG-1];
    assign out_data  = stg_q[NSTG-1].data;

endmodule
